sar_adc_ctrl: RTL

// - Successive-approximation ADC sequencer built around the PWM DAC + external analog comparator.
// - Drives the DAC duty cycle and period, waits for the RC filter to settle, samples the comparator and binary-searches the result.
// - Delivers each result over a valid/ready handshake to the display/averaging logic.

---
 rtl/sar_adc_pkg.sv | 16 +
 rtl/sar_settle_timer.sv | 30 +++
 rtl/sar_adc_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the SAR ADC sequencer.
package sar_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SET,
    SETTLE,
    DECIDE,
    DONE
  } sar_state_t;

  // Conversions per start when averaging is built in, and the matching divide shift.
  localparam int unsigned AVG_COUNT = 4;
  localparam int unsigned AVG_SHIFT = 2;

endpackage

// File: rtl/sar_settle_timer.sv
// Counts settle ticks (one per DAC PWM period) and flags the PERIODS-th one.
module sar_settle_timer #(
  parameter int unsigned PERIODS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_done
);

  localparam int unsigned CW = (PERIODS < 2) ? 1 : $clog2(PERIODS);
  localparam logic [CW-1:0] LAST = CW'(PERIODS - 1);

  logic [CW-1:0] r_count;

  assign o_done = i_tick && (r_count == LAST);

  // Tick counter: clear has priority, wraps to zero on the terminal tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_tick) begin
      r_count <= o_done ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC sequencer driving a PWM DAC and sampling an
// external comparator. Define SAR_ADC_AVG_EN to average four conversions per start.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned SETTLE_PERIODS = 4,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             dac_enable,
  output logic [WIDTH-1:0] dac_duty,
  output logic [WIDTH-1:0] dac_count,
  input  logic             dac_zero,
  input  logic             comp_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int unsigned BW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam logic [BW-1:0] MSB = BW'(WIDTH - 1);

  sar_state_t             r_state;
  sar_state_t             w_next;
  logic [BW-1:0]          r_bit;
  logic [WIDTH-1:0]       r_code;
  logic [WIDTH-1:0]       w_code_next;
  logic [WIDTH-1:0]       w_trial;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_comp;
  logic                   w_tick;
  logic                   w_settled;
  logic                   w_last_pass;

  assign dac_count = '1;
  assign w_comp    = r_sync[SYNC_STAGES-1];
  assign w_tick    = dac_zero && dac_enable && (r_state == SETTLE);
  assign w_trial   = r_code | (WIDTH'(1) << r_bit);

  // Comparator synchronizer; its latency is hidden inside the settle window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], comp_in};
    end
  end

  sar_settle_timer #(
    .PERIODS(SETTLE_PERIODS)
  ) u_settle (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (r_state == SET),
    .i_tick  (w_tick),
    .o_done  (w_settled)
  );

  // Current code with the bit under trial replaced by the comparator decision.
  always_comb begin
    w_code_next        = r_code;
    w_code_next[r_bit] = w_comp;
  end

`ifdef SAR_ADC_AVG_EN
  logic [1:0]       r_avg_cnt;
  logic [WIDTH+1:0] r_sum;
  logic [WIDTH+1:0] w_sum_next;

  assign w_sum_next  = r_sum + {2'b00, w_code_next};
  assign w_last_pass = (r_avg_cnt == 2'(AVG_COUNT - 1));
`else
  assign w_last_pass = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    w_next       = r_state;
    busy         = (r_state != IDLE);
    dac_enable   = (r_state != IDLE);
    result_valid = (r_state == DONE);
    case (r_state)
      IDLE:    if (start) w_next = SET;
      SET:     w_next = SETTLE;
      SETTLE:  if (w_settled) w_next = DECIDE;
      DECIDE:  w_next = ((r_bit == '0) && w_last_pass) ? DONE : SET;
      DONE:    if (result_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Binary-search datapath: trial code, bit index, DAC duty and result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit    <= '0;
      r_code   <= '0;
      dac_duty <= '0;
      result   <= '0;
`ifdef SAR_ADC_AVG_EN
      r_sum     <= '0;
      r_avg_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bit  <= MSB;
            r_code <= '0;
`ifdef SAR_ADC_AVG_EN
            r_sum     <= '0;
            r_avg_cnt <= '0;
`endif
          end
        end
        SET: dac_duty <= w_trial;
        DECIDE: begin
          if (r_bit == '0) begin
`ifdef SAR_ADC_AVG_EN
            // Final bit of one pass: accumulate, then either restart the
            // search from the MSB or publish the truncated mean.
            r_sum <= w_sum_next;
            if (w_last_pass) begin
              result <= w_sum_next[AVG_SHIFT +: WIDTH];
              r_code <= w_code_next;
            end else begin
              r_avg_cnt <= r_avg_cnt + 2'd1;
              r_bit     <= MSB;
              r_code    <= '0;
            end
`else
            result <= w_code_next;
            r_code <= w_code_next;
`endif
          end else begin
            r_bit  <= r_bit - BW'(1);
            r_code <= w_code_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
